uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter data_size, default 8: UART byte width; all byte ports use this width.
REQ-002 Parameter num_regs, default 16: number of host-visible registers, each data_size bits wide.
REQ-003 Parameter timeout, default 100000: number of clk cycles allowed between bytes of one frame.
REQ-004 Single clock domain; reset is asynchronous and active-high.
REQ-005 clk  input  1: rising-edge clock.
REQ-006 reset  input  1: asynchronous reset, active-high.
REQ-007 rx_empty  input  1: UART rx FIFO empty flag.
REQ-008 r_data  input  data_size: rx FIFO head byte, show-ahead, valid whenever rx_empty=0.
REQ-009 rd_uart  output  1: rx FIFO pop strobe.
REQ-010 tx_full  input  1: UART tx FIFO full flag.
REQ-011 wr_uart  output  1: tx FIFO push strobe.
REQ-012 w_data  output  data_size: byte to push; valid when wr_uart=1.
REQ-013 reg_out  output  num_regs*data_size: flattened register file; register i occupies bits [i*data_size +: data_size].
REQ-014 err_count  output  8: saturating count of protocol errors.
REQ-015 busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-016 Frame formats:
- Write frame: 0x57 ('W'), addr, data. Response is 0x4B ('K').
- Read frame: 0x52 ('R'), addr. Response is the contents of reg[addr].
- Any other first byte: response is 0x3F ('?').
REQ-017 FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
REQ-018 Pop rule: rd_uart = 1 combinationally only in IDLE, GET_ADDR or GET_DATA, and only when rx_empty=0. Each pop lasts exactly one cycle, and the byte is captured on that same clock edge.
REQ-019 IDLE transitions, on a pop:
- 'W' or 'R' -> GET_ADDR, with the command latched.
- Any other byte -> EXEC, with the response set to '?'.
REQ-020 GET_ADDR transitions, on a pop: latch addr; a 'W' frame goes to GET_DATA, an 'R' frame goes to EXEC.
REQ-021 GET_DATA transitions, on a pop: latch data, then go to EXEC.
REQ-022 EXEC takes exactly one cycle:
- Valid 'W': write reg[addr] and select response 'K'.
- Valid 'R': select response reg[addr].
- addr >= num_regs: select '?' and do not write any register.
REQ-023 SEND: wr_uart = 1 combinationally when tx_full=0, w_data = the selected response, then go to IDLE. While tx_full=1, hold in SEND with wr_uart=0 and w_data stable.
REQ-024 Latency: wr_uart asserts 2 cycles after the final pop of a frame when tx_full=0 (pop edge, then EXEC, then SEND).
REQ-025 No rx pops occur in EXEC or SEND; received bytes wait in the rx FIFO.
REQ-026 Timeout counter:
- Clears on every pop.
- Increments each cycle in GET_ADDR or GET_DATA while rx_empty=1.
- When it reaches timeout-1: go to IDLE, send no response, increment err_count.
REQ-027 err_count increments once per unknown command, once per out-of-range addr and once per timeout, and saturates at 255.
REQ-028 A write to reg[addr] in EXEC is visible on reg_out the following cycle; a read of the same address in a later frame returns the written value.
REQ-029 Width rule: addr compares as an unsigned data_size-bit value; only the low $clog2(num_regs) bits index the register file.

Reset
REQ-030 While reset=1, independent of clk:
- FSM is in IDLE.
- All registers, err_count, the timeout counter and all latches are 0.
- rd_uart=0, wr_uart=0, w_data=0, busy=0.
REQ-031 Reset asserted mid-frame or in SEND discards the frame; no partial write and no response is produced.
REQ-032 The first pop occurs no earlier than the first rising clk edge after reset deasserts.

Structure
REQ-033 Package uart_pkg holds:
- Command constants CMD_WR=0x57, CMD_RD=0x52, RSP_ACK=0x4B, RSP_ERR=0x3F.
- The FSM state enum.
REQ-034 One sub-module, uart_reg_file: num_regs x data_size registers with a synchronous write port, a combinational read port, async active-high reset and a flattened output. The FSM, timeout counter and err_count stay in uart_cmd_responder.

Verification
REQ-035 Write then read:
- Push 0x57,0x03,0xA5 -> one wr_uart with w_data=0x4B, and reg_out[31:24]=0xA5.
- Then push 0x52,0x03 -> w_data=0xA5.
REQ-036 Bad command and bad address:
- Push 0x41 -> w_data=0x3F, err_count=1.
- Push 0x57,0x10,0x11 -> w_data=0x3F, err_count=2, all registers unchanged.
REQ-037 Backpressure: hold tx_full=1 for 20 cycles after frame 0x52,0x00 -> wr_uart stays 0 and w_data is stable. Release tx_full -> exactly one push of 0x00 on the next cycle.
REQ-038 Timeout (timeout=50): push 0x57,0x02, then leave the FIFO empty -> return to IDLE after 50 cycles, no push, err_count increments. Then push 0x52,0x02 -> w_data=0x00.
REQ-039 Reset mid-frame: assert reset after 0x57,0x05 is popped -> no push. Then push 0x52,0x05 -> response 0x00.
REQ-040 Back-to-back: pre-load 5 complete frames into the rx FIFO -> 5 responses in order, and no pop occurs during any EXEC or SEND cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared command bytes and FSM state encoding for the UART command responder.
package uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND
  } state_t;

endpackage

// File: rtl/uart_reg_file.sv
// Host-visible register file: one synchronous write port, one combinational
// read port and a flattened view of every register.
module uart_reg_file #(
  parameter int data_size = 8,
  parameter int num_regs  = 16,
  localparam int addr_w   = (num_regs > 1) ? $clog2(num_regs) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [addr_w-1:0]             waddr,
  input  logic [data_size-1:0]          wdata,
  input  logic [addr_w-1:0]             raddr,
  output logic [data_size-1:0]          rdata,
  output logic [num_regs*data_size-1:0] regs_flat
);

  logic [data_size-1:0] regs [num_regs];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < num_regs; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < num_regs; i++) regs_flat[i*data_size +: data_size] = regs[i];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-oriented command responder: parses W/R frames from the rx FIFO, accesses
// the register file and pushes one response byte per frame to the tx FIFO.
module uart_cmd_responder #(
  parameter int data_size = 8,
  parameter int num_regs  = 16,
  parameter int timeout   = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_empty,
  input  logic [data_size-1:0]          r_data,
  output logic                          rd_uart,
  input  logic                          tx_full,
  output logic                          wr_uart,
  output logic [data_size-1:0]          w_data,
  output logic [num_regs*data_size-1:0] reg_out,
  output logic [7:0]                    err_count,
  output logic                          busy
);
  import uart_pkg::*;

  localparam int AW = (num_regs > 1) ? $clog2(num_regs) : 1;
  localparam int TW = $clog2(timeout + 1);
  localparam logic [data_size:0]   NUM_REGS_EXT = (data_size + 1)'(num_regs);
  localparam logic [TW-1:0]        TMO_LAST     = TW'(timeout - 1);
  localparam logic [data_size-1:0] B_WR  = data_size'(CMD_WR);
  localparam logic [data_size-1:0] B_RD  = data_size'(CMD_RD);
  localparam logic [data_size-1:0] B_ACK = data_size'(RSP_ACK);
  localparam logic [data_size-1:0] B_ERR = data_size'(RSP_ERR);

  state_t               state_q, state_d;
  logic [data_size-1:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, rsp_q, rsp_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [7:0]           err_q, err_d;
  logic                 reg_we, pop_ok, addr_ok, cmd_ok;
  logic [data_size-1:0] rd_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  uart_reg_file #(
    .data_size(data_size),
    .num_regs (num_regs)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (reg_we),
    .waddr    (addr_q[AW-1:0]),
    .wdata    (data_q),
    .raddr    (addr_q[AW-1:0]),
    .rdata    (rd_data),
    .regs_flat(reg_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    reg_we  = 1'b0;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    // reset gates the pop so a non-empty FIFO is never drained while held in reset
    pop_ok  = !rx_empty && !reset;
    addr_ok = ({1'b0, addr_q} < NUM_REGS_EXT);
    cmd_ok  = (cmd_q == B_WR) || (cmd_q == B_RD);

    case (state_q)
      IDLE: begin
        if (pop_ok) begin
          rd_uart = 1'b1;
          tmo_d   = '0;
          cmd_d   = r_data;
          if (r_data == B_WR || r_data == B_RD) begin
            state_d = GET_ADDR;
          end else begin
            rsp_d   = B_ERR;
            state_d = EXEC;
          end
        end
      end
      GET_ADDR, GET_DATA: begin
        if (pop_ok) begin
          rd_uart = 1'b1;
          tmo_d   = '0;
          if (state_q == GET_ADDR) begin
            addr_d  = r_data;
            state_d = (cmd_q == B_WR) ? GET_DATA : EXEC;
          end else begin
            data_d  = r_data;
            state_d = EXEC;
          end
        end else if (tmo_q == TMO_LAST) begin
          // stalled frame is abandoned silently; only the error counter records it
          tmo_d   = '0;
          err_d   = sat_inc(err_q);
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      EXEC: begin
        state_d = SEND;
        if (cmd_ok && addr_ok) begin
          if (cmd_q == B_WR) begin
            reg_we = 1'b1;
            rsp_d  = B_ACK;
          end else begin
            rsp_d  = rd_data;
          end
        end else begin
          rsp_d = B_ERR;
          err_d = sat_inc(err_q);
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_data    = rsp_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomised and directed bench for uart_cmd_responder with a frame-level
// reference model fed from the bytes the DUT actually pops.
module tb_uart_cmd_responder;
  localparam int DW  = 8;
  localparam int NR  = 16;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic reset, rx_empty, tx_full, rd_uart, wr_uart, busy;
  logic [DW-1:0] r_data, w_data;
  logic [NR*DW-1:0] reg_out;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_responder #(.data_size(DW), .num_regs(NR), .timeout(TMO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .reg_out(reg_out),
    .err_count(err_count), .busy(busy)
  );

  // rx FIFO model and reference state
  logic [7:0] rx_q[$];
  logic [7:0] fb[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         lat_q[$];
  logic [7:0] m_regs[NR];
  int         m_err;
  bit         pop_pend = 0;
  bit         awaiting = 0;
  int         cyc = 0, done_cyc = 0, pop_viol = 0, pops = 0;

  function automatic void refresh();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? '0 : rx_q[0];
  endfunction

  function automatic int frame_len(input logic [7:0] b0);
    if (b0 == 8'h57) return 3;
    if (b0 == 8'h52) return 2;
    return 1;
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_exec();
    logic [7:0] rsp;
    if (fb[0] == 8'h57) begin
      if (fb[1] < NR) begin m_regs[fb[1]] = fb[2]; rsp = 8'h4B; end
      else begin rsp = 8'h3F; bump_err(); end
    end else if (fb[0] == 8'h52) begin
      if (fb[1] < NR) rsp = m_regs[fb[1]];
      else begin rsp = 8'h3F; bump_err(); end
    end else begin
      rsp = 8'h3F; bump_err();
    end
    exp_q.push_back(rsp);
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_err = 0;
  endfunction

  // observe pops and pushes on the negedge, when inputs and outputs are settled
  always @(negedge clk) begin
    cyc++;
    pop_pend = 0;
    if (reset) begin
      fb.delete();
      awaiting = 0;
    end else begin
      if (rd_uart) begin
        pop_pend = 1;
        pops++;
        if (awaiting) pop_viol++;
        fb.push_back(r_data);
        if (fb.size() == frame_len(fb[0])) begin
          model_exec();
          fb.delete();
          awaiting = 1;
          done_cyc = cyc;
        end
      end
      if (wr_uart) begin
        got_q.push_back(w_data);
        lat_q.push_back(cyc - done_cyc);
        awaiting = 0;
      end
    end
  end

  always @(posedge clk) begin
    logic [7:0] dump;
    #1;
    if (pop_pend && rx_q.size() > 0) dump = rx_q.pop_front();
    refresh();
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    refresh();
  endtask

  task automatic flush();
    got_q.delete(); lat_q.delete(); exp_q.delete();
    pop_viol = 0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
  endtask

  function automatic logic [7:0] take_got();
    if (got_q.size() == 0) return 8'hxx;
    return got_q.pop_front();
  endfunction

  function automatic int take_lat();
    if (lat_q.size() == 0) return -1;
    return lat_q.pop_front();
  endfunction

  function automatic logic [7:0] take_exp();
    if (exp_q.size() == 0) return 8'hzz;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    step();
    push(8'h41);
    @(negedge clk); #1;
    checks++; if (rd_uart !== 1'b0) begin errors++; $display("FAIL reset_rd_uart: got %b want 0", rd_uart); end
    checks++; if (wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr_uart: got %b want 0", wr_uart); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL reset_w_data: got %h want 00", w_data); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    checks++; if (reg_out !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", reg_out); end
    step();
    rx_q.delete(); refresh();
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_write_read();
    logic [7:0] g; int l;
    flush(); step();
    push(8'h57); push(8'h03); push(8'hA5);
    wait_rsp(1, 50);
    g = take_got(); l = take_lat();
    checks++; if (g !== 8'h4B) begin errors++; $display("FAIL wr_ack: got %h want 4B", g); end
    checks++; if (l !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", l); end
    checks++; if (reg_out[31:24] !== 8'hA5) begin errors++; $display("FAIL wr_reg3: got %h want A5", reg_out[31:24]); end
    step();
    push(8'h52); push(8'h03);
    wait_rsp(1, 50);
    g = take_got(); l = take_lat();
    checks++; if (g !== 8'hA5) begin errors++; $display("FAIL rd_reg3: got %h want A5", g); end
    checks++; if (l !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", l); end
  endtask

  task automatic test_bad();
    logic [7:0] g;
    logic [NR*DW-1:0] saved;
    flush(); step();
    push(8'h41);
    wait_rsp(1, 50);
    g = take_got();
    checks++; if (g !== 8'h3F) begin errors++; $display("FAIL bad_cmd_rsp: got %h want 3F", g); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_cmd_err: got %0d want 1", err_count); end
    saved = m_flat();
    step();
    push(8'h57); push(8'h10); push(8'h11);
    wait_rsp(1, 50);
    g = take_got();
    checks++; if (g !== 8'h3F) begin errors++; $display("FAIL bad_addr_rsp: got %h want 3F", g); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL bad_addr_err: got %0d want 2", err_count); end
    checks++; if (reg_out !== saved) begin errors++; $display("FAIL bad_addr_regs: got %h want %h", reg_out, saved); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ref_w, g;
    int bad_cycles = 0;
    flush(); step();
    tx_full = 1'b1;
    push(8'h52); push(8'h00);
    repeat (5) @(negedge clk);
    #1 ref_w = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (wr_uart !== 1'b0 || w_data !== ref_w) bad_cycles++;
    end
    checks++; if (bad_cycles != 0 || got_q.size() != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles, %0d pushes want 0", bad_cycles, got_q.size()); end
    step();
    tx_full = 1'b0;
    @(negedge clk); #1;
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_release: got %0d pushes want 1", got_q.size()); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_single: got %0d pushes want 1", got_q.size()); end
    g = take_got();
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL bp_data: got %h want 00", g); end
  endtask

  task automatic test_timeout();
    int p0, n, k;
    logic [7:0] g;
    flush(); step();
    p0 = pops;
    push(8'h57); push(8'h02);
    k = 0;
    while (pops < p0 + 2 && k < 20) begin @(negedge clk); #1; k++; end
    n = 0;
    while (busy && n < 200) begin @(negedge clk); #1; n++; end
    checks++; if (n != TMO + 1) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", n, TMO + 1); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL tmo_no_push: got %0d pushes want 0", got_q.size()); end
    fb.delete();
    bump_err();
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL tmo_err: got %0d want %0d", err_count, m_err); end
    step();
    push(8'h52); push(8'h02);
    wait_rsp(1, 50);
    g = take_got();
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL tmo_readback: got %h want 00", g); end
  endtask

  task automatic test_reset_mid();
    int p0, k;
    logic [7:0] g;
    flush(); step();
    p0 = pops;
    push(8'h57); push(8'h05);
    k = 0;
    while (pops < p0 + 2 && k < 20) begin @(negedge clk); #1; k++; end
    step();
    reset = 1'b1;
    model_reset();
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (err_count !== 8'd0 || reg_out !== '0) begin errors++; $display("FAIL rst_mid_clear: got err %0d regs %h want 0", err_count, reg_out); end
    reset = 1'b0;
    repeat (10) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_no_push: got %0d pushes want 0", got_q.size()); end
    push(8'h52); push(8'h05);
    wait_rsp(1, 50);
    g = take_got();
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL rst_mid_read: got %h want 00", g); end
  endtask

  task automatic push_random_frame();
    int kind;
    logic [7:0] b;
    kind = $urandom_range(0, 2);
    if (kind == 0) begin
      push(8'h57); push(8'($urandom_range(0, 19))); push(8'($urandom));
    end else if (kind == 1) begin
      push(8'h52); push(8'($urandom_range(0, 17)));
    end else begin
      b = 8'($urandom);
      while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
      push(b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e;
    int l;
    flush(); step();
    for (int i = 0; i < 5; i++) push_random_frame();
    wait_rsp(5, 200);
    for (int i = 0; i < 5; i++) begin
      g = take_got(); e = take_exp(); l = take_lat();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_rsp%0d: got %h want %h", i, g, e); end
      checks++; if (l !== 2) begin errors++; $display("FAIL b2b_lat%0d: got %0d want 2", i, l); end
    end
    checks++; if (pop_viol != 0) begin errors++; $display("FAIL b2b_pop_in_exec_send: got %0d pops want 0", pop_viol); end
    checks++; if (reg_out !== m_flat()) begin errors++; $display("FAIL b2b_regs: got %h want %h", reg_out, m_flat()); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL b2b_err: got %0d want %0d", err_count, m_err); end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    int k;
    for (int f = 0; f < 30; f++) begin
      flush(); step();
      repeat ($urandom_range(0, 3)) step();
      push_random_frame();
      k = 0;
      while (got_q.size() < 1 && k < 100) begin
        step();
        tx_full = ($urandom_range(0, 2) == 0);
        k++;
      end
      tx_full = 1'b0;
      g = take_got(); e = take_exp();
      checks++; if (g !== e) begin errors++; $display("FAIL rand_rsp%0d: got %h want %h", f, g, e); end
    end
    step(); step();
    checks++; if (reg_out !== m_flat()) begin errors++; $display("FAIL rand_regs: got %h want %h", reg_out, m_flat()); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rand_err: got %0d want %0d", err_count, m_err); end
    checks++; if (pop_viol != 0) begin errors++; $display("FAIL rand_pop_in_exec_send: got %0d want 0", pop_viol); end
  endtask

  initial begin
    reset   = 1'b1;
    tx_full = 1'b0;
    refresh();
    model_reset();
    test_reset();
    test_write_read();
    test_bad();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
